// File: rtl/light_phase_scheduler.sv
// Pedestrian-crossing light controller: a GREEN/YELLOW/RED FSM steering a small datapath
// that tracks pending requests, round-robin ownership of the RED phase and a grant counter.
module light_phase_scheduler #(
    parameter int unsigned GREEN_CYC  = 8,
    parameter int unsigned YELLOW_CYC = 2,
    parameter int unsigned RED_CYC    = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       req_a_i,
    input  logic       req_b_i,
    output logic [2:0] light_o,
    output logic [1:0] walk_o,
    output logic       grant_a_o,
    output logic       grant_b_o,
    output logic [7:0] served_o
);

    typedef enum logic [1:0] {ST_GREEN, ST_YELLOW, ST_RED} state_t;

    localparam logic [3:0] G_LAST = 4'(GREEN_CYC - 1);
    localparam logic [3:0] Y_LAST = 4'(YELLOW_CYC - 1);
    localparam logic [3:0] R_LAST = 4'(RED_CYC - 1);

    state_t     state_q, state_d;
    logic [3:0] timer_q, timer_d;
    logic       pend_a_q, pend_a_d;
    logic       pend_b_q, pend_b_d;
    logic       owner_q, owner_d;   // 0 = A, 1 = B
    logic       last_q, last_d;
    logic [7:0] served_q, served_d;

    logic tmr_clr, tmr_inc, ld_owner, clr_pend, inc_served;
    logic have_req, winner;

    assign have_req = pend_a_q | pend_b_q;
    // Sole requester wins; on a tie the one not served last time wins.
    assign winner   = (pend_a_q & pend_b_q) ? ~last_q : pend_b_q;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= ST_GREEN;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        tmr_clr    = 1'b0;
        ld_owner   = 1'b0;
        clr_pend   = 1'b0;
        inc_served = 1'b0;
        unique case (state_q)
            ST_GREEN: begin
                if (timer_q >= G_LAST && have_req) begin
                    state_d = ST_YELLOW;
                    tmr_clr = 1'b1;
                end
            end
            ST_YELLOW: begin
                if (timer_q == Y_LAST) begin
                    state_d    = ST_RED;
                    tmr_clr    = 1'b1;
                    ld_owner   = have_req;
                    clr_pend   = have_req;
                    inc_served = have_req;
                end
            end
            ST_RED: begin
                if (timer_q == R_LAST) begin
                    state_d = ST_GREEN;
                    tmr_clr = 1'b1;
                end
            end
            default: begin
                state_d = ST_GREEN;
                tmr_clr = 1'b1;
            end
        endcase
        tmr_inc = ~tmr_clr;
    end

    // ---------------- datapath ----------------
    always_comb begin
        timer_d = timer_q;
        if (tmr_clr)                        timer_d = 4'd0;
        else if (tmr_inc && timer_q != 4'hF) timer_d = timer_q + 4'd1;

        // A request arriving on the grant edge re-arms pending even for the winner.
        pend_a_d = req_a_i | (pend_a_q & ~(clr_pend & ~winner));
        pend_b_d = req_b_i | (pend_b_q & ~(clr_pend &  winner));

        owner_d  = ld_owner ? winner : owner_q;
        last_d   = ld_owner ? winner : last_q;
        served_d = served_q + {7'd0, inc_served};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            timer_q  <= 4'd0;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            served_q <= 8'd0;
        end else begin
            timer_q  <= timer_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            served_q <= served_d;
        end
    end

    // ---------------- output decode (registered state only) ----------------
    logic in_red, first_red;
    assign in_red    = (state_q == ST_RED);
    assign first_red = in_red && (timer_q == 4'd0);

    always_comb begin
        light_o = 3'b001;
        unique case (state_q)
            ST_YELLOW: light_o = 3'b010;
            ST_RED:    light_o = 3'b100;
            default:   light_o = 3'b001;
        endcase
    end

    assign walk_o    = in_red ? {owner_q, ~owner_q} : 2'b00;
    assign grant_a_o = first_red & ~owner_q;
    assign grant_b_o = first_red &  owner_q;
    assign served_o  = served_q;

endmodule
